// File: rtl/lp_calc_pkg.sv
// Shared constants and types for the low-power calculator controller slice.
package lp_calc_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // A divide with a zero divisor is flagged rather than computed.
    function automatic logic is_div_zero(input logic [1:0] op, input logic [OPND_W-1:0] b);
        return (op == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/lp_calc_arith.sv
// Purely combinational 4-bit calculator datapath producing an 8-bit result.
module lp_calc_arith
    import lp_calc_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [1:0]        op,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] a_w;
    logic [RES_W-1:0] b_w;

    assign a_w = {{(RES_W-OPND_W){1'b0}}, a};
    assign b_w = {{(RES_W-OPND_W){1'b0}}, b};

    // Select the operation; subtraction wraps and a zero divisor yields zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a_w + b_w;
            OP_SUB: result = a_w - b_w;
            OP_MUL: result = a_w * b_w;
            OP_DIV: result = (b == '0) ? '0 : (a_w / b_w);
        endcase
    end

endmodule

// File: rtl/lp_calc_rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last granted requester.
module lp_calc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last_q;

    // Pick the winner: on a tie the requester not served last wins.
    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        if (req == 2'b11) begin
            gnt_idx = ~last_q;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
        if (en && (req != 2'b00)) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Record the granted requester whenever a grant actually transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/lp_calc_ctrl.sv
// Sequencer for the calculator datapath: arbitration, operand isolation,
// last-result reuse, registered response and saturating statistics.
module lp_calc_ctrl
    import lp_calc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*OPND_W-1:0]    req_a,
    input  logic [2*OPND_W-1:0]    req_b,
    input  logic [3:0]             req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [RES_W-1:0]       rsp_result,
    output logic                   rsp_dz,
    output logic                   rsp_hit,
    output logic                   busy,
    output logic [CNT_W-1:0]       stat_ops,
    output logic [CNT_W-1:0]       stat_hits
);

    state_e            state_q;
    state_e            state_d;
    logic [OPND_W-1:0] iso_a;
    logic [OPND_W-1:0] iso_b;
    logic [1:0]        iso_op;
    logic [RES_W-1:0]  res_q;
    logic [RES_W-1:0]  arith_res;
    logic              dz_q;
    logic              cache_vld_q;
    logic              id_q;
    logic              hit_q;
    logic [1:0]        grant;
    logic              gidx;
    logic              arb_en;
    logic              xfer;
    logic              hit;
    logic [OPND_W-1:0] sel_a;
    logic [OPND_W-1:0] sel_b;
    logic [1:0]        sel_op;

    assign arb_en = rst_n && (state_q == ST_IDLE);
    assign xfer   = (grant != 2'b00);

    assign sel_a  = gidx ? req_a[OPND_W +: OPND_W] : req_a[0 +: OPND_W];
    assign sel_b  = gidx ? req_b[OPND_W +: OPND_W] : req_b[0 +: OPND_W];
    assign sel_op = gidx ? req_op[3:2] : req_op[1:0];

    assign hit = CACHE_EN && cache_vld_q && ({sel_a, sel_b, sel_op} == {iso_a, iso_b, iso_op});

    lp_calc_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .req     (req_valid),
        .gnt     (grant),
        .gnt_idx (gidx)
    );

    lp_calc_arith u_arith (
        .a      (iso_a),
        .b      (iso_b),
        .op     (iso_op),
        .result (arith_res)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the handshake/response outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = grant;
        rsp_valid  = (state_q == ST_RESP);
        busy       = (state_q != ST_IDLE);
        rsp_id     = 1'b0;
        rsp_result = '0;
        rsp_dz     = 1'b0;
        rsp_hit    = 1'b0;
        if (state_q == ST_RESP) begin
            rsp_id     = id_q;
            rsp_result = res_q;
            rsp_dz     = dz_q;
            rsp_hit    = hit_q;
        end
        case (state_q)
            ST_IDLE: if (xfer) state_d = hit ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Isolation registers load only on a miss; the result is captured in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iso_a       <= '0;
            iso_b       <= '0;
            iso_op      <= '0;
            res_q       <= '0;
            dz_q        <= 1'b0;
            cache_vld_q <= 1'b0;
            id_q        <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            if (xfer) begin
                id_q  <= gidx;
                hit_q <= hit;
                if (!hit) begin
                    iso_a  <= sel_a;
                    iso_b  <= sel_b;
                    iso_op <= sel_op;
                end
            end
            if (state_q == ST_EXEC) begin
                res_q       <= arith_res;
                dz_q        <= is_div_zero(iso_op, iso_b);
                cache_vld_q <= 1'b1;
            end
        end
    end

    // Saturating counters of accepted requests and cache hits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_hits <= '0;
        end else if (xfer) begin
            if (stat_ops != '1) begin
                stat_ops <= stat_ops + CNT_W'(1);
            end
            if (hit && (stat_hits != '1)) begin
                stat_hits <= stat_hits + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lp_calc_ctrl.sv
// Directed testbench for lp_calc_ctrl with hand-computed expected values.
module tb_lp_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_dz;
    logic        rsp_hit;
    logic        busy;
    logic [15:0] stat_ops;
    logic [15:0] stat_hits;

    int compared   = 0;
    int mismatched = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    lp_calc_ctrl #(
        .CNT_W    (16),
        .CACHE_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_dz     (rsp_dz),
        .rsp_hit    (rsp_hit),
        .busy       (busy),
        .stat_ops   (stat_ops),
        .stat_hits  (stat_hits)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] op);
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        req_op    = op;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".flags"}, {26'd0, rsp_valid, rsp_id, rsp_dz, rsp_hit, busy, |req_ready}, 32'd0);
        checkOutput({tag, ".result"}, rsp_result, 32'd0);
        checkOutput({tag, ".ops"}, stat_ops, 32'd0);
        checkOutput({tag, ".hits"}, stat_hits, 32'd0);
    endtask

    // Runs one transaction starting just after a rising edge with the DUT idle;
    // returns just after the rising edge on which the response handshake occurs.
    task automatic runTxn(input string tag, input logic [1:0] valid, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] op, input logic exp_id,
                          input logic exp_hit, input logic [7:0] exp_res, input logic exp_dz,
                          input int stall);
        applyStimulus(valid, a, b, op);
        @(negedge clk);
        checkOutput({tag, ".grant"}, req_ready, exp_id ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid[exp_id] = 1'b0;
        if (!exp_hit) begin
            @(negedge clk);
            checkOutput({tag, ".exec"}, {29'd0, rsp_valid, busy, |req_ready}, 32'b010);
            @(posedge clk); #1;
        end
        for (int k = 0; k <= stall; k++) begin
            rsp_ready = (k == stall);
            @(negedge clk);
            checkOutput({tag, ".rspflags"}, {26'd0, rsp_valid, rsp_id, rsp_dz, rsp_hit, busy, |req_ready},
                        {26'd0, 1'b1, exp_id, exp_dz, exp_hit, 1'b1, 1'b0});
            checkOutput({tag, ".result"}, rsp_result, exp_res);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
    endtask

    // Directed sequence of scenarios, ending with the summary line.
    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(2'b00, 8'h00, 8'h00, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;

        runTxn("add", 2'b01, 8'h07, 8'h09, 4'b0000, 1'b0, 1'b0, 8'd16, 1'b0, 0);
        checkOutput("add.ops", stat_ops, 32'd1);

        runTxn("sub", 2'b10, 8'h30, 8'h50, 4'b0100, 1'b1, 1'b0, 8'hFE, 1'b0, 0);
        runTxn("subhit", 2'b10, 8'h30, 8'h50, 4'b0100, 1'b1, 1'b1, 8'hFE, 1'b0, 0);
        checkOutput("subhit.iso", {22'd0, dut.iso_a, dut.iso_b, dut.iso_op}, {22'd0, 4'd3, 4'd5, 2'b01});
        checkOutput("subhit.hits", stat_hits, 32'd1);
        checkOutput("subhit.ops", stat_ops, 32'd3);

        runTxn("div0", 2'b01, 8'h09, 8'h00, 4'b0011, 1'b0, 1'b0, 8'd0, 1'b1, 0);
        runTxn("div0hit", 2'b01, 8'h09, 8'h00, 4'b0011, 1'b0, 1'b1, 8'd0, 1'b1, 0);
        runTxn("div", 2'b01, 8'h0F, 8'h04, 4'b0011, 1'b0, 1'b0, 8'd3, 1'b0, 0);
        runTxn("mul", 2'b01, 8'h0F, 8'h0F, 4'b0010, 1'b0, 1'b0, 8'd225, 1'b0, 0);
        checkOutput("mul.ops", stat_ops, 32'd7);
        checkOutput("mul.hits", stat_hits, 32'd2);

        // Last grant went to requester 0, so requester 1 wins this tie.
        runTxn("stall", 2'b11, 8'h61, 8'h71, 4'b1000, 1'b1, 1'b0, 8'h2A, 1'b0, 5);
        runTxn("pend", 2'b01, 8'h61, 8'h71, 4'b1000, 1'b0, 1'b0, 8'h02, 1'b0, 0);
        checkOutput("pend.ops", stat_ops, 32'd9);

        rst_n = 1'b0;
        req_valid = 2'b00;
        @(posedge clk); #1;
        checkReset("rst2");
        rst_n = 1'b1;

        runTxn("rr1", 2'b11, 8'h42, 8'h23, 4'b0100, 1'b0, 1'b0, 8'd5, 1'b0, 0);
        runTxn("rr2", 2'b11, 8'h42, 8'h23, 4'b0110, 1'b1, 1'b0, 8'd2, 1'b0, 0);
        runTxn("rr3", 2'b11, 8'h82, 8'h23, 4'b1110, 1'b0, 1'b0, 8'd6, 1'b0, 0);
        runTxn("rr4", 2'b11, 8'h82, 8'h23, 4'b1101, 1'b1, 1'b0, 8'd4, 1'b0, 0);
        runTxn("rr5", 2'b01, 8'h82, 8'h23, 4'b1101, 1'b0, 1'b0, 8'hFF, 1'b0, 0);
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("rr.idle", {30'd0, busy, rsp_valid}, 32'd0);

        @(posedge clk); #1;
        applyStimulus(2'b01, 8'h07, 8'h09, 4'b0000);
        @(negedge clk);
        checkOutput("midrst.grant", req_ready, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        checkOutput("midrst.exec", busy, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkReset("rst3");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst.dropped", {30'd0, rsp_valid, busy}, 32'd0);
        @(posedge clk); #1;
        runTxn("again", 2'b01, 8'h07, 8'h09, 4'b0000, 1'b0, 1'b0, 8'd16, 1'b0, 0);
        checkOutput("again.ops", stat_ops, 32'd1);
        checkOutput("again.hits", stat_hits, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lp_calc_ctrl.md
# lp_calc_ctrl

Sequencer and two-port arbiter for the low-power calculator datapath `lp_calc_arith`. It accepts operation requests from two requesters and grants them round-robin. It holds the arithmetic unit's operands in isolation registers so the combinational datapath toggles only when a new, different operation is issued. It returns a registered result over a valid/ready response channel, with a divide-by-zero flag and power-statistics counters.

## Interface
Parameters:
- `CNT_W`, 16: width of the statistics counters.
- `CACHE_EN`, 1: 1 enables the last-result reuse (hit) path; 0 makes every request recompute.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  2: request valid, one bit per requester.
- `req_ready`  out  2: request accepted this cycle; at most one bit set.
- `req_a`  in  8: two packed 4-bit A operands; requester i uses bits [4i+3:4i].
- `req_b`  in  8: two packed 4-bit B operands; same packing as `req_a`.
- `req_op`  in  4: two packed 2-bit opcodes; requester i uses bits [2i+1:2i]. Codes: 00 add, 01 sub, 10 mul, 11 div.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  1: index of the requester that is being answered.
- `rsp_result`  out  8: result.
- `rsp_dz`  out  1: division by zero occurred (op 11 with B = 0).
- `rsp_hit`  out  1: result came from the cache, not a recompute.
- `busy`  out  1: controller state is not IDLE.
- `stat_ops`  out  CNT_W: count of accepted requests; saturates at all-ones.
- `stat_hits`  out  CNT_W: count of accepted requests served from the cache; saturates at all-ones.

## Operation
The controller has three states: IDLE, EXEC, RESP.

**IDLE**
- Arbitrate among the asserted `req_valid` bits.
- Round-robin: the requester other than `last_q` wins a tie. `last_q` resets to 1, so requester 0 wins the first tie.
- Assert `req_ready[g]` for the winner g, combinationally. The request transfers in that same cycle.
- On a transfer, `last_q` is set to g. `last_q` does not change if no transfer occurs.
- Hit check: a hit is `CACHE_EN && cache_vld_q && {a,b,op}` equal to the isolation registers.
  - On a hit, go to RESP with the cached result and dz flag, and set `rsp_hit = 1`.
  - On a miss, load the isolation registers with g's operands and go to EXEC.

**EXEC**
- Lasts exactly one cycle.
- Capture the datapath output into `res_q`, compute `dz_q = (op==11 && b==0)`, set `cache_vld_q = 1`, and go to RESP with `rsp_hit = 0`.

**RESP**
- Hold `rsp_valid = 1` with id, result, dz and hit stable until `rsp_valid && rsp_ready`, then go to IDLE.
- No request is accepted while in EXEC or RESP: `req_ready = 0`.

**Isolation registers**
- These are the only drivers of the datapath inputs.
- They change only on a miss transfer, never on a hit and never while idle.

**Arithmetic**
- Results are 8 bits. Add: max 30. Mul: max 225.
- Sub wraps modulo 256 (two's complement), e.g. 3 − 5 = 8'hFE.
- Div is an integer quotient. Divide by zero gives result 0 and `rsp_dz = 1`.
- A cache hit on a divide-by-zero returns 0 with `rsp_dz = 1`.

**Statistics**
- `stat_ops` increments on every request transfer.
- `stat_hits` increments on every hit transfer.
- Both counters saturate and never wrap.

**Reset** (when `rst_n = 0` at a rising edge)
- State goes to IDLE. `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_dz`, `rsp_hit`, `busy` and `req_ready` all read 0.
- Isolation registers, `res_q` and both counters clear to 0. `cache_vld_q` clears to 0. `last_q` is set to 1.
- A transaction in flight is dropped without a response.

## Timing
- Take the transfer cycle as T.
- Miss: EXEC occupies T+1 and `rsp_valid` rises at T+2. Latency is 2 cycles.
- Hit: `rsp_valid` rises at T+1. Latency is 1 cycle.
- Response handshake: if `rsp_ready` is high in the first RESP cycle, RESP lasts exactly one cycle. The earliest next transfer is the cycle after the response handshake.
- Peak throughput: one request per 3 cycles on a miss, one per 2 cycles on a hit.
- `busy` is high from T+1 until the response handshake completes.
- A requester must hold `req_valid` and its operands stable until it sees its `req_ready`.

## Structure
- Package `lp_calc_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`;
  - state encodings `ST_IDLE`, `ST_EXEC`, `ST_RESP`;
  - operand width 4 and result width 8.
- One sub-module, `lp_calc_rr_arb2`: the two-requester round-robin arbiter that owns `last_q`.
- `lp_calc_arith` is instantiated once, with its inputs driven by the isolation registers.

## Test plan
1. **Add, cold cache.** After reset, requester 0 sends a=7, b=9, op=00. Required: `req_ready = 01` at T; `rsp_valid` at T+2 with result 16, id 0, hit 0, dz 0; `stat_ops = 1`.
2. **Sub wrap, then hit.** Requester 1 sends 3, 5, op=01. Required: result 8'hFE on a miss. Then the same request again. Required: response at T+1 with `rsp_hit = 1`, isolation registers unchanged, `stat_hits = 1`.
3. **Divide by zero and exact divide.** Send 9, 0, op=11. Required: result 0, dz 1. Then send 15, 4, op=11. Required: result 3, dz 0. Then send 15, 15, op=10. Required: result 225.
4. **Fairness.** Both `req_valid` held high with distinct ops over 4 transactions. Required: grants alternate 0, 1, 0, 1, with requester 0 first after reset.
5. **Backpressure.** Hold `rsp_ready = 0` for 5 cycles. Required: response fields stable, `req_ready = 0` throughout; transfer completes on the cycle `rsp_ready` rises.
6. **Reset mid-transaction.** Assert `rst_n = 0` during EXEC. Required: the next cycle shows all outputs 0 and counters 0. A repeated request after reset is a miss (cache invalidated).
